// File: rtl/instr_encoder_pkg.sv
// Opcode/funct map, request select codes and FSM states shared by the
// instruction encoder and the pipeline control decoder.
package instr_encoder_pkg;

    // Primary opcodes
    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_SLTI  = 6'h0a;
    localparam logic [5:0] OPC_ANDI  = 6'h0c;
    localparam logic [5:0] OPC_ORI   = 6'h0d;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SH    = 6'h29;
    localparam logic [5:0] OPC_SW    = 6'h2b;

    // R-type funct codes; jr uses the project-specific 6'h18
    localparam logic [5:0] FN_JR     = 6'h18;
    localparam logic [5:0] FN_ADD    = 6'h20;
    localparam logic [5:0] FN_SUB    = 6'h22;
    localparam logic [5:0] FN_AND    = 6'h24;
    localparam logic [5:0] FN_OR     = 6'h25;
    localparam logic [5:0] FN_NOR    = 6'h27;
    localparam logic [5:0] FN_SLT    = 6'h2a;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_ADDI    = 4'd1,
        OP_AND     = 4'd2,
        OP_ANDI    = 4'd3,
        OP_J       = 4'd4,
        OP_JR      = 4'd5,
        OP_LW      = 4'd6,
        OP_NOR     = 4'd7,
        OP_OR      = 4'd8,
        OP_ORI     = 4'd9,
        OP_SLT     = 4'd10,
        OP_SLTI    = 4'd11,
        OP_SH      = 4'd12,
        OP_SW      = 4'd13,
        OP_SUB     = 4'd14,
        OP_ILLEGAL = 4'd15
    } op_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ENC  = 2'd1,
        ST_WR   = 2'd2,
        ST_FULL = 2'd3
    } state_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

    // Immediate is passed through untouched; extension happens in the decoder.
    function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request channel into the instruction encoder: valid/ready plus instruction fields.
interface instr_encoder_if;
    logic        enc_valid;
    logic        enc_ready;
    logic [3:0]  op_sel;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [25:0] target;

    modport master (
        output enc_valid, op_sel, rs, rt, rd, imm, target,
        input  enc_ready
    );

    modport slave (
        input  enc_valid, op_sel, rs, rt, rd, imm, target,
        output enc_ready
    );
endinterface

// File: rtl/instr_word_fmt.sv
// Combinational formatter: mnemonic select plus fields to a 32-bit instruction word.
module instr_word_fmt
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_sel)
            OP_ADD:  word = r_word(rs, rt, rd, FN_ADD);
            OP_AND:  word = r_word(rs, rt, rd, FN_AND);
            OP_NOR:  word = r_word(rs, rt, rd, FN_NOR);
            OP_OR:   word = r_word(rs, rt, rd, FN_OR);
            OP_SLT:  word = r_word(rs, rt, rd, FN_SLT);
            OP_SUB:  word = r_word(rs, rt, rd, FN_SUB);
            // jr only carries rs; rt/rd/shamt are forced to zero
            OP_JR:   word = r_word(rs, 5'd0, 5'd0, FN_JR);
            OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
            OP_ANDI: word = i_word(OPC_ANDI, rs, rt, imm);
            OP_LW:   word = i_word(OPC_LW, rs, rt, imm);
            OP_ORI:  word = i_word(OPC_ORI, rs, rt, imm);
            OP_SLTI: word = i_word(OPC_SLTI, rs, rt, imm);
            OP_SH:   word = i_word(OPC_SH, rs, rt, imm);
            OP_SW:   word = i_word(OPC_SW, rs, rt, imm);
            OP_J:    word = {OPC_J, target};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts requests, formats them and writes words
// sequentially into instruction memory through a one-cycle write strobe.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [ADDR_W-1:0] start_addr,
    instr_encoder_if.slave    enc,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              error
);

    localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

    state_e            state_reg;
    logic              ready_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [ADDR_W:0]   count_reg;
    logic              full_reg;
    logic              error_reg;
    logic [ADDR_W-1:0] ptr_reg;

    logic [3:0]        op_reg;
    logic [4:0]        rs_reg;
    logic [4:0]        rt_reg;
    logic [4:0]        rd_reg;
    logic [15:0]       imm_reg;
    logic [25:0]       target_reg;

    logic [31:0]       fmt_word;
    logic              fmt_illegal;

    instr_word_fmt u_fmt (
        .op_sel  (op_reg),
        .rs      (rs_reg),
        .rt      (rt_reg),
        .rd      (rd_reg),
        .imm     (imm_reg),
        .target  (target_reg),
        .word    (fmt_word),
        .illegal (fmt_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            ready_reg  <= 1'b1;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            error_reg  <= 1'b0;
            ptr_reg    <= '0;
            op_reg     <= '0;
            rs_reg     <= '0;
            rt_reg     <= '0;
            rd_reg     <= '0;
            imm_reg    <= '0;
            target_reg <= '0;
        end else if (clear) begin
            // Abort anything in flight; the memory bus keeps its last address/data
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
            we_reg    <= 1'b0;
            count_reg <= '0;
            full_reg  <= 1'b0;
            error_reg <= 1'b0;
            ptr_reg   <= start_addr;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (enc.enc_valid) begin
                        op_reg     <= enc.op_sel;
                        rs_reg     <= enc.rs;
                        rt_reg     <= enc.rt;
                        rd_reg     <= enc.rd;
                        imm_reg    <= enc.imm;
                        target_reg <= enc.target;
                        ready_reg  <= 1'b0;
                        state_reg  <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    if (fmt_illegal) begin
                        error_reg <= 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        we_reg    <= 1'b1;
                        addr_reg  <= ptr_reg;
                        wdata_reg <= fmt_word;
                        state_reg <= ST_WR;
                    end
                end
                ST_WR: begin
                    we_reg    <= 1'b0;
                    ptr_reg   <= ptr_reg + PTR_ONE;
                    count_reg <= count_reg + COUNT_ONE;
                    if (count_reg == LAST_COUNT) begin
                        full_reg  <= 1'b1;
                        state_reg <= ST_FULL;
                    end else begin
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_FULL: begin
                    // Parked until clear or reset
                    ready_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign enc.enc_ready = ready_reg;
    assign imem_we       = we_reg;
    assign imem_addr     = addr_reg;
    assign imem_wdata    = wdata_reg;
    assign count         = count_reg;
    assign full          = full_reg;
    assign error         = error_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors plus randomized
// requests against a field-level reference model.
module tb_instr_encoder;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              clear;
    logic [ADDR_W-1:0] start_addr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              error;

    instr_encoder_if enc_bus ();

    instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .start_addr (start_addr),
        .enc        (enc_bus),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .error      (error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_ptr   = 0;
    int m_count = 0;
    bit m_full  = 0;
    bit m_err   = 0;

    // Word built from the instruction-format rules with plain arithmetic.
    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int imm, input int tgt,
                                             output bit ill);
        longint w;
        longint opc;
        longint fn;
        int     kind; // 0 R-type, 1 I-type, 2 j, 3 jr, 4 illegal
        opc = 0; fn = 0; kind = 4; ill = 0;
        case (op)
            0:  begin kind = 0; fn = 'h20; end
            1:  begin kind = 1; opc = 'h08; end
            2:  begin kind = 0; fn = 'h24; end
            3:  begin kind = 1; opc = 'h0c; end
            4:  kind = 2;
            5:  kind = 3;
            6:  begin kind = 1; opc = 'h23; end
            7:  begin kind = 0; fn = 'h27; end
            8:  begin kind = 0; fn = 'h25; end
            9:  begin kind = 1; opc = 'h0d; end
            10: begin kind = 0; fn = 'h2a; end
            11: begin kind = 1; opc = 'h0a; end
            12: begin kind = 1; opc = 'h29; end
            13: begin kind = 1; opc = 'h2b; end
            14: begin kind = 0; fn = 'h22; end
            default: kind = 4;
        endcase
        case (kind)
            0: w = longint'(rs) * 2**21 + longint'(rt) * 2**16 + longint'(rd) * 2**11 + fn;
            1: w = opc * 2**26 + longint'(rs) * 2**21 + longint'(rt) * 2**16 + longint'(imm);
            2: w = 2 * 2**26 + longint'(tgt);
            3: w = longint'(rs) * 2**21 + 24;
            default: begin w = 0; ill = 1; end
        endcase
        return w[31:0];
    endfunction

    task automatic do_clear(input int start);
        @(negedge clk);
        clear = 1'b1;
        start_addr = ADDR_W'(start);
        @(negedge clk);
        clear = 1'b0;
        m_ptr = start % (2**ADDR_W); m_count = 0; m_full = 0; m_err = 0;
    endtask

    // Drives one request, waits (bounded) for the handshake and records what
    // the write port did over the following four cycles.
    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int imm, input int tgt,
                        output bit accepted, output int nwr, output int delay,
                        output logic [ADDR_W-1:0] waddr, output logic [31:0] wdata,
                        output bit ready_after);
        @(negedge clk);
        enc_bus.op_sel = 4'(op); enc_bus.rs = 5'(rs); enc_bus.rt = 5'(rt);
        enc_bus.rd = 5'(rd); enc_bus.imm = 16'(imm); enc_bus.target = 26'(tgt);
        enc_bus.enc_valid = 1'b1;
        accepted = 0; nwr = 0; delay = -1; waddr = '0; wdata = '0; ready_after = 0;
        for (int i = 0; i < 8; i++) begin
            if (imem_we === 1'b1) nwr++;
            if (enc_bus.enc_ready === 1'b1) begin
                accepted = 1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            enc_bus.enc_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 enc_bus.enc_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (imem_we === 1'b1) begin
                nwr++;
                if (delay < 0) begin
                    delay = k; waddr = imem_addr; wdata = imem_wdata;
                end
            end
            if (k == 3) ready_after = enc_bus.enc_ready;
        end
    endtask

    task automatic test_reset();
        enc_bus.enc_valid = 1'b0; enc_bus.op_sel = '0; enc_bus.rs = '0; enc_bus.rt = '0;
        enc_bus.rd = '0; enc_bus.imm = '0; enc_bus.target = '0;
        clear = 1'b0; start_addr = '0; reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (enc_bus.enc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", enc_bus.enc_ready); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", imem_we); end
        checks++; if (imem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
        checks++; if (imem_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", imem_wdata); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
        reset = 1'b0;
        m_ptr = 0; m_count = 0; m_full = 0; m_err = 0;
        $display("reset: outputs checked");
    endtask

    task automatic test_basic_add();
        bit acc, rdy; int nwr, dly; logic [ADDR_W-1:0] a; logic [31:0] d;
        do_clear(0);
        send(0, 1, 2, 3, 0, 0, acc, nwr, dly, a, d, rdy);
        $display("add r3,r1,r2: acc=%0d writes=%0d delay=%0d addr=%0d data=%h", acc, nwr, dly, a, d);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL add_accept: got %b expected 1", acc); end
        checks++; if (nwr !== 1) begin errors++; $display("FAIL add_writes: got %0d expected 1", nwr); end
        checks++; if (dly !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", dly); end
        checks++; if (a !== 3'd0) begin errors++; $display("FAIL add_addr: got %0d expected 0", a); end
        checks++; if (d !== 32'h00221820) begin errors++; $display("FAIL add_data: got %h expected 00221820", d); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL add_count: got %0d expected 1", count); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL add_ready_after: got %b expected 1", rdy); end
        m_ptr = 1; m_count = 1;
    endtask

    typedef struct {
        int op; int rs; int rt; int rd; int imm; int tgt;
        logic [31:0] exp; int addr; bit clr_first;
    } vec_t;

    task automatic test_fixed_vectors();
        vec_t v[5];
        bit acc, rdy; int nwr, dly; logic [ADDR_W-1:0] a; logic [31:0] d;
        v[0] = '{1, 0, 5, 0, 'h0010, 0, 32'h20050010, 1, 0};
        v[1] = '{13, 29, 4, 0, 8, 0, 32'hAFA40008, 2, 0};
        v[2] = '{4, 0, 0, 0, 0, 'h40, 32'h08000040, 0, 1};
        v[3] = '{5, 31, 0, 0, 0, 0, 32'h03E00018, 1, 0};
        v[4] = '{12, 0, 1, 0, 2, 0, 32'hA4010002, 2, 0};
        foreach (v[i]) begin
            if (v[i].clr_first) do_clear(0);
            send(v[i].op, v[i].rs, v[i].rt, v[i].rd, v[i].imm, v[i].tgt, acc, nwr, dly, a, d, rdy);
            $display("vector %0d op=%0d: writes=%0d addr=%0d data=%h", i, v[i].op, nwr, a, d);
            checks++; if (nwr !== 1) begin errors++; $display("FAIL vec%0d_writes: got %0d expected 1", i, nwr); end
            checks++; if (d !== v[i].exp) begin errors++; $display("FAIL vec%0d_data: got %h expected %h", i, d, v[i].exp); end
            checks++; if (a !== ADDR_W'(v[i].addr)) begin errors++; $display("FAIL vec%0d_addr: got %0d expected %0d", i, a, v[i].addr); end
        end
        m_ptr = 3; m_count = 3;
    endtask

    task automatic test_illegal();
        bit acc, rdy; int nwr, dly; logic [ADDR_W-1:0] a; logic [31:0] d;
        do_clear(0);
        send(8, 7, 6, 5, 0, 0, acc, nwr, dly, a, d, rdy);
        send(15, 1, 1, 1, 1, 1, acc, nwr, dly, a, d, rdy);
        $display("illegal op: acc=%0d writes=%0d error=%b count=%0d", acc, nwr, error, count);
        checks++; if (nwr !== 0) begin errors++; $display("FAIL illegal_writes: got %0d expected 0", nwr); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL illegal_error: got %b expected 1", error); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL illegal_count: got %0d expected 1", count); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL illegal_ready: got %b expected 1", rdy); end
        send(9, 2, 3, 0, 'hBEEF, 0, acc, nwr, dly, a, d, rdy);
        $display("after illegal: writes=%0d addr=%0d data=%h", nwr, a, d);
        checks++; if (a !== 3'd1) begin errors++; $display("FAIL post_illegal_addr: got %0d expected 1", a); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL error_sticky: got %b expected 1", error); end
        do_clear(5);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL clear_error: got %b expected 0", error); end
    endtask

    task automatic test_full_wrap();
        bit acc, rdy; int nwr, dly; logic [ADDR_W-1:0] a; logic [31:0] d;
        int exp_addr[4] = '{6, 7, 0, 1};
        do_clear(6);
        for (int i = 0; i < DEPTH; i++) begin
            send(14, i, i + 1, i + 2, 0, 0, acc, nwr, dly, a, d, rdy);
            $display("fill %0d: addr=%0d data=%h full=%b", i, a, d, full);
            checks++; if (a !== ADDR_W'(exp_addr[i])) begin errors++; $display("FAIL fill%0d_addr: got %0d expected %0d", i, a, exp_addr[i]); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", full); end
        checks++; if (enc_bus.enc_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", enc_bus.enc_ready); end
        checks++; if (count !== 4'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d expected %0d", count, DEPTH); end
        send(0, 1, 1, 1, 0, 0, acc, nwr, dly, a, d, rdy);
        $display("request while full: acc=%0d writes=%0d", acc, nwr);
        checks++; if (acc !== 1'b0) begin errors++; $display("FAIL full_ignore_accept: got %b expected 0", acc); end
        checks++; if (nwr !== 0) begin errors++; $display("FAIL full_ignore_writes: got %0d expected 0", nwr); end
        do_clear(2);
        checks++; if (enc_bus.enc_ready !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL clear_from_full: got ready=%b full=%b expected 1/0", enc_bus.enc_ready, full); end
        send(3, 4, 5, 0, 'h00FF, 0, acc, nwr, dly, a, d, rdy);
        $display("after clear: addr=%0d data=%h", a, d);
        checks++; if (a !== 3'd2) begin errors++; $display("FAIL clear_restart_addr: got %0d expected 2", a); end
    endtask

    task automatic test_clear_abort();
        bit acc, rdy; int nwr, dly; logic [ADDR_W-1:0] a; logic [31:0] d;
        int seen;
        do_clear(0);
        @(negedge clk);
        enc_bus.op_sel = 4'd0; enc_bus.rs = 5'd1; enc_bus.rt = 5'd2; enc_bus.rd = 5'd3;
        enc_bus.enc_valid = 1'b1;
        @(posedge clk);
        #1 enc_bus.enc_valid = 1'b0;
        clear = 1'b1; start_addr = 3'd4;
        @(posedge clk);
        #1 clear = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (imem_we === 1'b1) seen++;
        end
        $display("clear during ENC: writes=%0d count=%0d ready=%b", seen, count, enc_bus.enc_ready);
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_writes: got %0d expected 0", seen); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", count); end
        checks++; if (enc_bus.enc_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", enc_bus.enc_ready); end
        m_ptr = 4; m_count = 0; m_full = 0; m_err = 0;
        send(10, 1, 2, 3, 0, 0, acc, nwr, dly, a, d, rdy);
        checks++; if (a !== 3'd4) begin errors++; $display("FAIL abort_restart_addr: got %0d expected 4", a); end
    endtask

    task automatic test_reset_during_wr();
        bit acc, rdy; int nwr, dly; logic [ADDR_W-1:0] a; logic [31:0] d;
        do_clear(3);
        send(1, 3, 3, 0, 'h1234, 0, acc, nwr, dly, a, d, rdy);
        send(15, 0, 0, 0, 0, 0, acc, nwr, dly, a, d, rdy);
        @(negedge clk);
        enc_bus.op_sel = 4'd6; enc_bus.rs = 5'd9; enc_bus.rt = 5'd8; enc_bus.imm = 16'h0040;
        enc_bus.enc_valid = 1'b1;
        @(posedge clk);
        #1 enc_bus.enc_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL rst_wr_strobe: got %b expected 1", imem_we); end
        reset = 1'b1;
        @(negedge clk);
        $display("reset during WR: we=%b addr=%0d data=%h count=%0d error=%b", imem_we, imem_addr, imem_wdata, count, error);
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_wr_we: got %b expected 0", imem_we); end
        checks++; if (imem_addr !== '0 || imem_wdata !== 32'h0) begin errors++; $display("FAIL rst_wr_bus: got %0d/%h expected 0/0", imem_addr, imem_wdata); end
        checks++; if (count !== '0 || full !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rst_wr_status: got count=%0d full=%b error=%b expected 0/0/0", count, full, error); end
        checks++; if (enc_bus.enc_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready: got %b expected 1", enc_bus.enc_ready); end
        reset = 1'b0;
        m_ptr = 0; m_count = 0; m_full = 0; m_err = 0;
    endtask

    task automatic test_random();
        bit acc, rdy, ill; int nwr, dly; logic [ADDR_W-1:0] a; logic [31:0] d, exp;
        int op, rs, rt, rd, imm, tgt, exp_addr;
        do_clear($urandom_range(0, 7));
        for (int n = 0; n < 40; n++) begin
            if ((m_full && $urandom_range(0, 2) != 0) || $urandom_range(0, 9) == 0)
                do_clear($urandom_range(0, 7));
            op = $urandom_range(0, 15);
            rs = $urandom_range(0, 31); rt = $urandom_range(0, 31); rd = $urandom_range(0, 31);
            imm = $urandom_range(0, 65535); tgt = $urandom_range(0, 2**26 - 1);
            exp = ref_word(op, rs, rt, rd, imm, tgt, ill);
            exp_addr = m_ptr;
            send(op, rs, rt, rd, imm, tgt, acc, nwr, dly, a, d, rdy);
            $display("rand %0d op=%0d: acc=%0d writes=%0d addr=%0d data=%h exp=%h", n, op, acc, nwr, a, d, exp);
            if (m_full) begin
                checks++; if (acc !== 1'b0 || nwr !== 0) begin errors++; $display("FAIL rand%0d_full_ignore: got acc=%0d writes=%0d expected 0/0", n, acc, nwr); end
            end else if (ill) begin
                m_err = 1;
                checks++; if (nwr !== 0 || rdy !== 1'b1) begin errors++; $display("FAIL rand%0d_illegal: got writes=%0d ready=%b expected 0/1", n, nwr, rdy); end
            end else begin
                m_ptr = (m_ptr + 1) % (2**ADDR_W);
                m_count++;
                if (m_count == DEPTH) m_full = 1;
                checks++; if (nwr !== 1 || dly !== 2) begin errors++; $display("FAIL rand%0d_strobe: got writes=%0d delay=%0d expected 1/2", n, nwr, dly); end
                checks++; if (d !== exp) begin errors++; $display("FAIL rand%0d_data: got %h expected %h", n, d, exp); end
                checks++; if (a !== ADDR_W'(exp_addr)) begin errors++; $display("FAIL rand%0d_addr: got %0d expected %0d", n, a, exp_addr); end
                checks++; if (rdy !== !m_full) begin errors++; $display("FAIL rand%0d_ready: got %b expected %b", n, rdy, !m_full); end
            end
            checks++;
            if (count !== 4'(m_count) || error !== m_err || full !== m_full) begin
                errors++;
                $display("FAIL rand%0d_status: got count=%0d error=%b full=%b expected %0d/%b/%b", n, count, error, full, m_count, m_err, m_full);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_fixed_vectors();
        test_illegal();
        test_full_wrap();
        test_clear_abort();
        test_reset_during_wr();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
